// File: rtl/ddr4_lanectrl_dly_stepper.sv
// Paced DELAY_LINE_MOVE/LOAD issuer for one DDR4 lane DQS delay line, wrapped in an
// HS_IO_CLK pause window, with out-of-range abort and completion reporting.
module ddr4_lanectrl_dly_stepper #(
    parameter int PAUSE_LEAD  = 2,
    parameter int PAUSE_TRAIL = 2,
    parameter int MOVE_GAP    = 4,
    parameter int CNT_W       = 8
) (
    input  logic             i_fab_clk,
    input  logic             i_arst_n,
    input  logic             i_req_valid,
    output logic             o_req_ready,
    input  logic [CNT_W-1:0] i_req_taps,
    input  logic             i_req_dir,
    input  logic             i_req_sel,
    input  logic             i_req_load,
    output logic             o_delay_line_sel,
    output logic             o_delay_line_direction,
    output logic             o_delay_line_move,
    output logic             o_delay_line_load,
    output logic             o_hs_io_clk_pause,
    input  logic             i_rx_delay_line_out_of_range,
    input  logic             i_tx_delay_line_out_of_range,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_err,
    output logic [CNT_W-1:0] o_taps_moved
);

    // state | meaning
    // IDLE  | waiting for a request, ready high
    // LEAD  | pause asserted ahead of the first pulse
    // MOVE  | one-cycle MOVE or LOAD pulse
    // GAP   | idle spacing after a pulse, OOR abort checked here
    // TRAIL | pause held after the last gap
    // DONE  | one-cycle completion pulse
    typedef enum logic [2:0] {
        S_IDLE,
        S_LEAD,
        S_MOVE,
        S_GAP,
        S_TRAIL,
        S_DONE
    } state_t;

    localparam int TMR_MAX_LT = (PAUSE_LEAD > PAUSE_TRAIL) ? PAUSE_LEAD : PAUSE_TRAIL;
    localparam int TMR_MAX    = (TMR_MAX_LT > MOVE_GAP) ? TMR_MAX_LT : MOVE_GAP;
    localparam int TMR_W      = (TMR_MAX < 2) ? 1 : $clog2(TMR_MAX);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [TMR_W-1:0]   r_tmr;
    logic [TMR_W-1:0]   w_tmr_ld;
    logic               w_tmr_zero;
    logic               w_accept;
    logic               w_abort;
    logic [CNT_W-1:0]   r_rem;
    logic [CNT_W-1:0]   r_taps_moved;
    logic               r_sel;
    logic               r_dir;
    logic               r_load;
    logic               r_err;
    logic               r_oor_q;

    always_ff @(posedge i_fab_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_accept          = 1'b0;
        w_abort           = 1'b0;
        w_tmr_zero        = (r_tmr == '0);
        w_tmr_ld          = '0;
        o_req_ready       = 1'b0;
        o_busy            = 1'b1;
        o_hs_io_clk_pause = 1'b0;
        o_delay_line_move = 1'b0;
        o_delay_line_load = 1'b0;
        o_done            = 1'b0;

        case (r_state)
            S_IDLE: begin
                o_req_ready = 1'b1;
                o_busy      = 1'b0;
                if (i_req_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_LEAD;
                end
            end
            S_LEAD: begin
                o_hs_io_clk_pause = 1'b1;
                if (w_tmr_zero) begin
                    w_state_nxt = ((r_rem == '0) && !r_load) ? S_TRAIL : S_MOVE;
                end
            end
            S_MOVE: begin
                o_hs_io_clk_pause = 1'b1;
                o_delay_line_move = !r_load;
                o_delay_line_load = r_load;
                w_state_nxt       = S_GAP;
            end
            S_GAP: begin
                o_hs_io_clk_pause = 1'b1;
                if (r_oor_q) begin
                    w_abort     = 1'b1;
                    w_state_nxt = S_TRAIL;
                end else if (w_tmr_zero) begin
                    w_state_nxt = (r_rem != '0) ? S_MOVE : S_TRAIL;
                end
            end
            S_TRAIL: begin
                o_hs_io_clk_pause = 1'b1;
                if (w_tmr_zero) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                o_done      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // Each timed state loads its length minus one and leaves on terminal count.
        case (w_state_nxt)
            S_LEAD:  w_tmr_ld = TMR_W'(PAUSE_LEAD - 1);
            S_GAP:   w_tmr_ld = TMR_W'(MOVE_GAP - 1);
            S_TRAIL: w_tmr_ld = TMR_W'(PAUSE_TRAIL - 1);
            default: w_tmr_ld = '0;
        endcase
    end

    always_ff @(posedge i_fab_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            r_tmr        <= '0;
            r_rem        <= '0;
            r_taps_moved <= '0;
            r_sel        <= 1'b0;
            r_dir        <= 1'b0;
            r_load       <= 1'b0;
            r_err        <= 1'b0;
            r_oor_q      <= 1'b0;
        end else begin
            r_oor_q <= r_sel ? i_tx_delay_line_out_of_range : i_rx_delay_line_out_of_range;

            if (w_state_nxt != r_state) begin
                r_tmr <= w_tmr_ld;
            end else if (!w_tmr_zero) begin
                r_tmr <= r_tmr - TMR_W'(1);
            end

            if (w_accept) begin
                r_sel        <= i_req_sel;
                r_dir        <= i_req_dir;
                r_load       <= i_req_load;
                r_rem        <= i_req_taps;
                r_taps_moved <= '0;
                r_err        <= 1'b0;
            end else if (r_state == S_MOVE) begin
                if (r_load) begin
                    r_rem <= '0;
                end else if (r_rem != '0) begin
                    r_rem        <= r_rem - CNT_W'(1);
                    r_taps_moved <= r_taps_moved + CNT_W'(1);
                end
            end else if (w_abort) begin
                r_err <= 1'b1;
                r_rem <= '0;
            end
        end
    end

    assign o_delay_line_sel       = r_sel;
    assign o_delay_line_direction = r_dir;
    assign o_err                  = r_err;
    assign o_taps_moved           = r_taps_moved;

endmodule

// File: tb/tb_ddr4_lanectrl_dly_stepper.sv
// Scoreboard bench for ddr4_lanectrl_dly_stepper: each request pushes its expected
// outcome, which is popped and compared when the DUT raises DONE.
module tb_ddr4_lanectrl_dly_stepper;
    localparam int PL = 2;
    localparam int PT = 2;
    localparam int G  = 4;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          valid = 1'b0;
    logic [CW-1:0] taps = '0;
    logic          dir = 1'b0;
    logic          sel = 1'b0;
    logic          load = 1'b0;
    logic          rx_oor = 1'b0;
    logic          tx_oor = 1'b0;
    logic          o_req_ready, o_dl_sel, o_dl_dir, o_dl_move, o_dl_load, o_pause;
    logic          o_busy, o_done, o_err;
    logic [CW-1:0] o_taps_moved;

    int n_vec = 0;
    int n_bad = 0;

    logic [CW-1:0] nx_taps;
    logic          nx_dir, nx_sel, nx_load;

    typedef struct {
        int done_cyc;
        int taps;
        int err;
        int n_move;
        int n_load;
        int first_p;
        int last_p;
    } exp_t;

    exp_t sb[$];

    ddr4_lanectrl_dly_stepper #(
        .PAUSE_LEAD (PL),
        .PAUSE_TRAIL(PT),
        .MOVE_GAP   (G),
        .CNT_W      (CW)
    ) dut (
        .i_fab_clk                   (clk),
        .i_arst_n                    (rst_n),
        .i_req_valid                 (valid),
        .o_req_ready                 (o_req_ready),
        .i_req_taps                  (taps),
        .i_req_dir                   (dir),
        .i_req_sel                   (sel),
        .i_req_load                  (load),
        .o_delay_line_sel            (o_dl_sel),
        .o_delay_line_direction      (o_dl_dir),
        .o_delay_line_move           (o_dl_move),
        .o_delay_line_load           (o_dl_load),
        .o_hs_io_clk_pause           (o_pause),
        .i_rx_delay_line_out_of_range(rx_oor),
        .i_tx_delay_line_out_of_range(tx_oor),
        .o_busy                      (o_busy),
        .o_done                      (o_done),
        .o_err                       (o_err),
        .o_taps_moved                (o_taps_moved)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, $signed(got), $signed(exp));
        end
    endtask

    // Expected outcome from the cycle formulas: pulse k at PL+k*(1+G); OOR input high in
    // cycles [os, os+ol) is seen registered in [os+1, os+ol] and aborts in the first GAP cycle.
    function automatic exp_t model(input int nt, input bit ld, input int os, input int ol);
        exp_t e;
        int   stride = 1 + G;
        int   n = ld ? 1 : nt;
        int   iss = n;
        int   abort_t = -1;
        if (os >= 0) begin
            for (int t = os + 1; t <= os + ol; t++) begin
                if (abort_t < 0 && t > PL && ((t - PL) % stride) != 0 && ((t - PL) / stride) < n)
                    abort_t = t;
            end
        end
        if (abort_t >= 0) begin
            iss        = (abort_t - PL) / stride + 1;
            e.done_cyc = abort_t + 1 + PT;
            e.err      = 1;
        end else begin
            e.done_cyc = PL + n * stride + PT;
            e.err      = 0;
        end
        e.taps    = ld ? 0 : iss;
        e.n_move  = ld ? 0 : iss;
        e.n_load  = ld ? iss : 0;
        e.first_p = (iss > 0) ? PL : -1;
        e.last_p  = (iss > 0) ? PL + (iss - 1) * stride : -1;
        return e;
    endfunction

    // Called at posedge+1 of an IDLE cycle; returns at posedge+1 of the IDLE cycle after DONE.
    task automatic run_req(input string name, input int nt, input bit d, input bit s, input bit ld,
                           input int os, input int ol, input bit keep, input bit pre_held);
        exp_t e;
        exp_t p;
        int   cyc = 0;
        int   n_move = 0, n_load = 0, first_p = -1, last_p = -1;
        bit   pause_bad = 0, busy_bad = 0, rdy_bad = 0, dir_bad = 0, sel_bad = 0, tmo = 0;
        bit   hi;
        e = model(nt, ld, os, ol);
        sb.push_back(e);
        if (!pre_held) begin
            taps  = CW'(nt);
            dir   = d;
            sel   = s;
            load  = ld;
            valid = 1'b1;
        end
        chk({name, "_ready_pre"}, o_req_ready, 1);
        @(posedge clk); #1;
        if (!keep) valid = 1'b0;
        while (1) begin
            hi = (os >= 0) && (cyc >= os) && (cyc < os + ol);
            if (s) begin tx_oor = hi; rx_oor = (cyc % 2) == 1; end
            else   begin rx_oor = hi; tx_oor = (cyc % 2) == 1; end
            if (o_dl_move) begin
                n_move++;
                if (first_p < 0) first_p = cyc;
                last_p = cyc;
            end
            if (o_dl_load) begin
                n_load++;
                if (first_p < 0) first_p = cyc;
                last_p = cyc;
            end
            if (o_done ? o_pause : !o_pause) pause_bad = 1;
            if (!o_busy) busy_bad = 1;
            if (o_req_ready) rdy_bad = 1;
            if (o_dl_dir !== d) dir_bad = 1;
            if (o_dl_sel !== s) sel_bad = 1;
            if (o_done) break;
            if (keep) begin
                taps = CW'($urandom);
                dir  = 1'($urandom);
                sel  = 1'($urandom);
                load = 1'($urandom);
            end
            if (cyc >= 3000) begin
                tmo = 1;
                break;
            end
            @(posedge clk); #1;
            cyc++;
        end
        if (keep) begin
            taps = nx_taps;
            dir  = nx_dir;
            sel  = nx_sel;
            load = nx_load;
        end
        p = sb.pop_front();
        if (tmo) begin
            chk({name, "_timeout"}, 1, 0);
        end else begin
            chk({name, "_done_cyc"}, cyc, p.done_cyc);
            chk({name, "_taps_moved"}, o_taps_moved, p.taps);
            chk({name, "_err"}, o_err, p.err);
            chk({name, "_n_move"}, n_move, p.n_move);
            chk({name, "_n_load"}, n_load, p.n_load);
            chk({name, "_first_pulse"}, first_p, p.first_p);
            chk({name, "_last_pulse"}, last_p, p.last_p);
            chk({name, "_pause_window_bad"}, pause_bad, 0);
            chk({name, "_busy_low_bad"}, busy_bad, 0);
            chk({name, "_ready_high_bad"}, rdy_bad, 0);
            chk({name, "_dir_bad"}, dir_bad, 0);
            chk({name, "_sel_bad"}, sel_bad, 0);
        end
        rx_oor = 1'b0;
        tx_oor = 1'b0;
        @(posedge clk); #1;
        chk({name, "_ready_after"}, o_req_ready, 1);
        chk({name, "_err_hold"}, o_err, p.err);
        chk({name, "_taps_hold"}, o_taps_moved, p.taps);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    initial begin
        #12;
        chk("rst_ready", o_req_ready, 1);
        chk("rst_busy", o_busy, 0);
        chk("rst_pause", o_pause, 0);
        chk("rst_pulses", {o_dl_move, o_dl_load, o_done}, 0);
        chk("rst_err_taps", {o_err, o_taps_moved}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rel_ready", o_req_ready, 1);
        chk("rel_outs", {o_busy, o_pause, o_dl_move, o_dl_load, o_done, o_err, o_dl_sel, o_dl_dir}, 0);

        run_req("dflt", 3, 1'b1, 1'b1, 1'b0, -1, 0, 1'b0, 1'b0);
        run_req("rxoor", 10, 1'b0, 1'b0, 1'b0, 18, 3, 1'b0, 1'b0);
        run_req("load", 7, 1'b1, 1'b0, 1'b1, -1, 0, 1'b0, 1'b0);
        run_req("zero", 0, 1'b0, 1'b1, 1'b0, -1, 0, 1'b0, 1'b0);
        run_req("txoor", 5, 1'b0, 1'b1, 1'b0, 3, 1, 1'b0, 1'b0);

        nx_taps = 8'd2;
        nx_dir  = 1'b1;
        nx_sel  = 1'b0;
        nx_load = 1'b0;
        run_req("held1", 1, 1'b0, 1'b1, 1'b0, -1, 0, 1'b1, 1'b0);
        run_req("held2", 2, 1'b1, 1'b0, 1'b0, -1, 0, 1'b0, 1'b1);

        rx_oor = 1'b1;
        tx_oor = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        run_req("idleoor", 1, 1'b1, 1'b0, 1'b0, -1, 0, 1'b0, 1'b0);
        run_req("max", 255, 1'b0, 1'b1, 1'b0, -1, 0, 1'b0, 1'b0);

        // Reset asserted in cycle 8 of a 5-tap request.
        taps  = 8'd5;
        dir   = 1'b1;
        sel   = 1'b1;
        load  = 1'b0;
        valid = 1'b1;
        @(posedge clk); #1;
        valid = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        chk("mid_pause_pre", o_pause, 1);
        chk("mid_taps_pre", o_taps_moved, 2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_pause", o_pause, 0);
        chk("mid_rst_busy", o_busy, 0);
        chk("mid_rst_move", o_dl_move, 0);
        chk("mid_rst_ready", o_req_ready, 1);
        chk("mid_rst_taps", o_taps_moved, 0);
        @(negedge clk);
        rst_n = 1'b1;
        begin
            bit replay = 0;
            for (int i = 0; i < 30; i++) begin
                @(posedge clk); #1;
                if (o_dl_move || o_dl_load || o_pause || o_busy || o_done) replay = 1;
            end
            chk("mid_no_replay", replay, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
